bcd_display_scanner: RTL

BCD_DISPLAY_SCANNER -- requirements
Module: bcd_display_scanner

---
 rtl/display_pkg.sv | 17 +
 rtl/bcd_to_seg.sv | 13 +
 rtl/bcd_display_scanner.sv | 111 +++++++++++
 3 files changed

// File: rtl/display_pkg.sv
// Shared constants for the multiplexed 5-digit seven-segment display:
// digit count, special segment codes and the BCD-to-segment table.
package display_pkg;

  localparam int NUM_DIGITS = 5;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'h3F;
  localparam logic [4:0] AN_OFF    = 5'h1F;

  // Active-low {g,f,e,d,c,b,a}; entry 0 sits at the LSB end, codes 10..15 show a dash.
  localparam logic [15:0][6:0] SEG_TABLE = {
    SEG_DASH, SEG_DASH, SEG_DASH, SEG_DASH, SEG_DASH, SEG_DASH,
    7'h10, 7'h00, 7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

endpackage

// File: rtl/bcd_to_seg.sv
// Combinational BCD to active-low seven-segment decoder.
module bcd_to_seg
  import display_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg_n
);

  always_comb begin
    seg_n = SEG_TABLE[bcd];
  end

endmodule

// File: rtl/bcd_display_scanner.sv
// Time-multiplexed 5-digit BCD display driver: double-buffered digits,
// per-slot deadtime, optional leading-zero blanking, registered outputs.
module bcd_display_scanner
  import display_pkg::*;
#(
  parameter int REFRESH_DIV = 2000,
  parameter int DEADTIME    = 2
) (
  input  logic       sysclk,
  input  logic       rst_n,
  input  logic [3:0] D5_in,
  input  logic [3:0] D4_in,
  input  logic [3:0] D3_in,
  input  logic [3:0] D2_in,
  input  logic [3:0] D1_in,
  input  logic       load,
  input  logic       blank_lz,
  output logic [6:0] seg_n,
  output logic [4:0] an_n,
  output logic       frame_tick
);

  localparam int              PW         = $clog2(REFRESH_DIV);
  localparam int              DW         = 4 * NUM_DIGITS;
  localparam logic [PW-1:0]   PRESC_LAST = PW'(REFRESH_DIV - 1);
  localparam logic [PW-1:0]   DEAD_END   = PW'(DEADTIME);
  localparam logic [2:0]      IDX_LAST   = 3'(NUM_DIGITS - 1);

  logic [PW-1:0] presc_q, presc_d;
  logic [2:0]    idx_q, idx_d;
  logic [DW-1:0] shadow_q, shadow_d;
  logic [DW-1:0] disp_q, disp_d;
  logic [6:0]    seg_q, seg_d;
  logic [4:0]    an_q, an_d;
  logic          tick_q, tick_d;

  logic          slot_wrap;
  logic          frame_wrap;
  logic [3:0]    digit;
  logic [6:0]    digit_seg;
  logic          blank_slot;
  logic          zero_run;

  // Slot/frame timing and the two-level digit buffer.
  always_comb begin
    slot_wrap  = (presc_q == PRESC_LAST);
    frame_wrap = slot_wrap && (idx_q == IDX_LAST);
    presc_d    = slot_wrap ? '0 : presc_q + 1'b1;
    idx_d      = idx_q;
    if (slot_wrap) begin
      idx_d = frame_wrap ? 3'd0 : idx_q + 3'd1;
    end
    shadow_d = load ? {D5_in, D4_in, D3_in, D2_in, D1_in} : shadow_q;
    // The display only ever takes a whole load, and only between frames.
    disp_d   = frame_wrap ? shadow_q : disp_q;
    tick_d   = frame_wrap;
  end

  // Digit select plus leading-zero detection, scanning from the MSD down.
  always_comb begin
    digit      = '0;
    blank_slot = 1'b0;
    zero_run   = 1'b1;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      zero_run = zero_run && (disp_q[4*k +: 4] == 4'd0);
      if (idx_q == 3'(k)) begin
        digit      = disp_q[4*k +: 4];
        blank_slot = blank_lz && (k != 0) && zero_run;
      end
    end
  end

  bcd_to_seg u_dec (
    .bcd   (digit),
    .seg_n (digit_seg)
  );

  always_comb begin
    seg_d = SEG_BLANK;
    an_d  = AN_OFF;
    if ((presc_q >= DEAD_END) && !blank_slot) begin
      seg_d = digit_seg;
      an_d  = ~(5'd1 << idx_q);
    end
  end

  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q  <= '0;
      idx_q    <= '0;
      shadow_q <= '0;
      disp_q   <= '0;
      seg_q    <= SEG_BLANK;
      an_q     <= AN_OFF;
      tick_q   <= 1'b0;
    end else begin
      presc_q  <= presc_d;
      idx_q    <= idx_d;
      shadow_q <= shadow_d;
      disp_q   <= disp_d;
      seg_q    <= seg_d;
      an_q     <= an_d;
      tick_q   <= tick_d;
    end
  end

  assign seg_n      = seg_q;
  assign an_n       = an_q;
  assign frame_tick = tick_q;

endmodule
